// File: rtl/decode_stage.sv
// RV64I decode stage: splits an instruction into register addresses, immediate and ALU
// controls, registers the bundle, and stalls read-after-write hazards using a busy-bit scoreboard.
module decode_stage #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int NUM_REGS       = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_instr,
    input  logic [BUS_DATA_WIDTH-1:0] in_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4:0]                addressA,
    output logic [4:0]                addressB,
    output logic [4:0]                addressC,
    output logic [BUS_DATA_WIDTH-1:0] imm,
    output logic [5:0]                alu_control,
    output logic                      muxB_control,
    output logic                      reg_write,
    output logic                      illegal,
    output logic [BUS_DATA_WIDTH-1:0] out_pc,
    input  logic                      wb_valid,
    input  logic [4:0]                wb_addr
);
    localparam int W = BUS_DATA_WIDTH;

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;

    typedef struct packed {
        logic [4:0]   ra;
        logic [4:0]   rb;
        logic [4:0]   rc;
        logic [W-1:0] imm;
        logic [5:0]   alu;
        logic         muxb;
        logic         rw;
        logic         ill;
        logic [W-1:0] pc;
    } bundle_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd, rs1, rs2;
    logic       is_shift_imm;
    logic [W-1:0] imm_i, imm_s, imm_u, imm_sh;

    assign opcode       = in_instr[6:0];
    assign funct3       = in_instr[14:12];
    assign rd           = in_instr[11:7];
    assign rs1          = in_instr[19:15];
    assign rs2          = in_instr[24:20];
    assign is_shift_imm = (funct3[1:0] == 2'b01);
    assign imm_i        = {{(W-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_s        = {{(W-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_u        = {{(W-32){in_instr[31]}}, in_instr[31:12], 12'b0};
    assign imm_sh       = {{(W-6){1'b0}}, in_instr[25:20]};

    bundle_t             dec, bundle_q;
    logic                rs1_used, rs2_used, hazard, transfer;
    logic                out_valid_q;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    always_comb begin
        dec      = '0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        dec.pc   = in_pc;
        case (opcode)
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                rs1_used = 1'b1;
                dec.ra   = rs1;
                dec.rc   = rd;
                dec.muxb = 1'b1;
                dec.imm  = is_shift_imm ? imm_sh : imm_i;
                dec.alu  = {opcode == OPC_OP_IMM_32, (funct3 == 3'b101) && in_instr[30], funct3, 1'b0};
            end
            OPC_OP, OPC_OP_32: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                dec.ra   = rs1;
                dec.rb   = rs2;
                dec.rc   = rd;
                dec.alu  = {opcode == OPC_OP_32, in_instr[30], funct3, 1'b0};
            end
            OPC_LUI: begin
                dec.rc   = rd;
                dec.imm  = imm_u;
                dec.muxb = 1'b1;
            end
            OPC_LOAD: begin
                rs1_used = 1'b1;
                dec.ra   = rs1;
                dec.rc   = rd;
                dec.imm  = imm_i;
                dec.muxb = 1'b1;
            end
            OPC_STORE: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                dec.ra   = rs1;
                dec.rb   = rs2;
                dec.rc   = rd;
                dec.imm  = imm_s;
                dec.muxb = 1'b1;
            end
            default: dec.ill = 1'b1;
        endcase
        dec.rw = !dec.ill && (opcode != OPC_STORE) && (rd != 5'd0);
    end

    // busy_q[0] is never set, so x0 sources can never stall.
    assign hazard   = (rs1_used && busy_q[rs1]) || (rs2_used && busy_q[rs2]);
    assign in_ready = reset_n && !flush && !hazard && (!out_valid_q || out_ready);
    assign transfer = in_valid && in_ready;

    // A retiring writeback and a new claim on the same register: the claim wins.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (wb_valid && (wb_addr != 5'd0)) busy_d[wb_addr] = 1'b0;
            if (transfer && dec.rw)            busy_d[dec.rc]  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bundle_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= '0;
        end else begin
            busy_q <= busy_d;
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (transfer) begin
                bundle_q    <= dec;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign addressA     = bundle_q.ra;
    assign addressB     = bundle_q.rb;
    assign addressC     = bundle_q.rc;
    assign imm          = bundle_q.imm;
    assign alu_control  = bundle_q.alu;
    assign muxB_control = bundle_q.muxb;
    assign reg_write    = bundle_q.rw;
    assign illegal      = bundle_q.ill;
    assign out_pc       = bundle_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus a randomized run against a behavioural
// model of the decode rules, the busy-bit scoreboard and the output handshake.
module tb_decode_stage;
    logic        clk, reset_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc, imm, out_pc;
    logic [4:0]  addressA, addressB, addressC, wb_addr;
    logic [5:0]  alu_control;
    logic        muxB_control, reg_write, illegal, wb_valid;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0]  a;
        logic [4:0]  b;
        logic [4:0]  c;
        logic [63:0] imm;
        logic [5:0]  alu;
        logic        mb;
        logic        rw;
        logic        ill;
        logic [63:0] pc;
    } exp_t;

    exp_t got;
    assign got = {addressA, addressB, addressC, imm, alu_control, muxB_control, reg_write, illegal, out_pc};

    decode_stage dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .addressA(addressA), .addressB(addressB), .addressC(addressC),
        .imm(imm), .alu_control(alu_control), .muxB_control(muxB_control),
        .reg_write(reg_write), .illegal(illegal), .out_pc(out_pc),
        .wb_valid(wb_valid), .wb_addr(wb_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic exp_t ref_dec(input logic [31:0] ins, input logic [63:0] pc);
        exp_t               e;
        logic [6:0]         opc;
        logic [2:0]         f3;
        logic signed [11:0] i12, s12;
        logic signed [31:0] u32;
        logic signed [63:0] iv, sv, uv;
        opc = ins[6:0];
        f3  = ins[14:12];
        i12 = ins[31:20];
        s12 = {ins[31:25], ins[11:7]};
        u32 = {ins[31:12], 12'h000};
        iv  = i12;
        sv  = s12;
        uv  = u32;
        e    = '0;
        e.pc = pc;
        case (opc)
            7'h13, 7'h1B: begin
                e.a   = ins[19:15];
                e.c   = ins[11:7];
                e.mb  = 1'b1;
                e.imm = (f3 == 3'd1 || f3 == 3'd5) ? {58'b0, ins[25:20]} : iv;
                e.alu = {opc == 7'h1B, (f3 == 3'd5) ? ins[30] : 1'b0, f3, 1'b0};
            end
            7'h33, 7'h3B: begin
                e.a   = ins[19:15];
                e.b   = ins[24:20];
                e.c   = ins[11:7];
                e.alu = {opc == 7'h3B, ins[30], f3, 1'b0};
            end
            7'h37: begin
                e.c   = ins[11:7];
                e.imm = uv;
                e.mb  = 1'b1;
            end
            7'h03: begin
                e.a   = ins[19:15];
                e.c   = ins[11:7];
                e.imm = iv;
                e.mb  = 1'b1;
            end
            7'h23: begin
                e.a   = ins[19:15];
                e.b   = ins[24:20];
                e.c   = ins[11:7];
                e.imm = sv;
                e.mb  = 1'b1;
            end
            default: e.ill = 1'b1;
        endcase
        e.rw = !e.ill && (opc != 7'h23) && (ins[11:7] != 5'd0);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clean();
        in_valid  = 1'b0;
        wb_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093;
        in_pc = 64'h1000; out_ready = 1'b1; wb_valid = 1'b0; wb_addr = 5'd0;
        #2;
        checks++;
        if (got !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got=%h out_valid=%b in_ready=%b required all 0", got, out_valid, in_ready);
        end
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (got !== '0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold got=%h out_valid=%b required 0", got, out_valid);
        end
        in_valid = 1'b0;
        reset_n  = 1'b1;
    endtask

    task automatic test_addi();
        logic [63:0] pc = {$urandom, $urandom};
        clean();
        in_instr = 32'h00500093; in_pc = pc; in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL addi_ready got=%b required 1", in_ready); end
        step();
        in_valid = 1'b0;
        in_instr = 32'h00008133;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || got !== ref_dec(32'h00500093, pc)) begin
            failures++;
            $display("FAIL addi_bundle got=%h v=%b required %h v=1", got, out_valid, ref_dec(32'h00500093, pc));
        end
        checks++;
        if (imm !== 64'd5 || alu_control !== 6'd0 || addressC !== 5'd1) begin
            failures++;
            $display("FAIL addi_fields imm=%h alu=%b rd=%0d required 5/000000/1", imm, alu_control, addressC);
        end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL addi_busy1 in_ready=%b required 0", in_ready); end
    endtask

    task automatic test_raw_hazard();
        logic [63:0] pc = {$urandom, $urandom};
        clean();
        in_instr = 32'h00500093; in_pc = pc; in_valid = 1'b1;
        step();
        in_instr = 32'h00108133;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin failures++; $display("FAIL raw_stall cycle=%0d in_ready=%b required 0", i, in_ready); end
            step();
        end
        wb_valid = 1'b1; wb_addr = 5'd1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL raw_no_bypass in_ready=%b required 0", in_ready); end
        step();
        wb_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL raw_release in_ready=%b required 1", in_ready); end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || got !== ref_dec(32'h00108133, pc) || addressB !== 5'd1 || muxB_control !== 1'b0) begin
            failures++;
            $display("FAIL raw_add got=%h v=%b required %h v=1", got, out_valid, ref_dec(32'h00108133, pc));
        end
    endtask

    task automatic test_sub_lui();
        logic [63:0] pc = {$urandom, $urandom};
        clean();
        in_instr = 32'h402081B3; in_pc = pc; in_valid = 1'b1;
        step();
        in_instr = 32'h800002B7; in_pc = pc + 64'd4;
        @(negedge clk);
        checks++;
        if (got !== ref_dec(32'h402081B3, pc) || alu_control !== 6'b010000 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL sub_bundle got=%h alu=%b required %h alu=010000", got, alu_control, ref_dec(32'h402081B3, pc));
        end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL lui_ready in_ready=%b required 1", in_ready); end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (got !== ref_dec(32'h800002B7, pc + 64'd4) || imm !== 64'hFFFFFFFF80000000 || addressA !== 5'd0 || muxB_control !== 1'b1) begin
            failures++;
            $display("FAIL lui_bundle got=%h required %h", got, ref_dec(32'h800002B7, pc + 64'd4));
        end
    endtask

    task automatic test_backpressure();
        exp_t e1, e2;
        e1 = ref_dec(32'h00100393, 64'h2000);
        e2 = ref_dec(32'h00200413, 64'h2004);
        clean();
        out_ready = 1'b0;
        in_instr = 32'h00100393; in_pc = 64'h2000; in_valid = 1'b1;
        step();
        in_instr = 32'h00200413; in_pc = 64'h2004;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || got !== e1) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got=%h rdy=%b v=%b required %h rdy=0 v=1", i, got, in_ready, out_valid, e1);
            end
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || got !== e1) begin
            failures++;
            $display("FAIL bp_drain1 got=%h rdy=%b required %h rdy=1", got, in_ready, e1);
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || got !== e2) begin
            failures++;
            $display("FAIL bp_drain2 got=%h v=%b required %h v=1", got, out_valid, e2);
        end
        step();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup out_valid=%b required 0", out_valid); end
    endtask

    task automatic test_illegal();
        clean();
        in_instr = 32'h0000007F; in_pc = 64'h3000; in_valid = 1'b1;
        step();
        in_instr = 32'h00000FFF; in_pc = 64'h3004;
        @(negedge clk);
        checks++;
        if (got !== ref_dec(32'h0000007F, 64'h3000) || illegal !== 1'b1 || reg_write !== 1'b0) begin
            failures++;
            $display("FAIL illegal_7f got=%h required %h", got, ref_dec(32'h0000007F, 64'h3000));
        end
        step();
        in_instr = 32'h01FF80B3; in_pc = 64'h3008;
        @(negedge clk);
        checks++;
        if (got !== ref_dec(32'h00000FFF, 64'h3004) || addressC !== 5'd0 || imm !== 64'd0) begin
            failures++;
            $display("FAIL illegal_fff got=%h required %h", got, ref_dec(32'h00000FFF, 64'h3004));
        end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL illegal_no_busy in_ready=%b required 1", in_ready); end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || got !== ref_dec(32'h01FF80B3, 64'h3008)) begin
            failures++;
            $display("FAIL illegal_follow got=%h required %h", got, ref_dec(32'h01FF80B3, 64'h3008));
        end
    endtask

    task automatic test_flush();
        clean();
        out_ready = 1'b0;
        in_instr = 32'h00500093; in_pc = 64'h4000; in_valid = 1'b1;
        step();
        in_instr = 32'h00108133; in_pc = 64'h4004;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_stall cycle=%0d in_ready=%b required 0", i, in_ready); end
            step();
        end
        flush = 1'b1; wb_valid = 1'b1; wb_addr = 5'd1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready in_ready=%b required 0", in_ready); end
        step();
        flush = 1'b0; wb_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_clear out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || got !== ref_dec(32'h00108133, 64'h4004)) begin
            failures++;
            $display("FAIL flush_accept got=%h v=%b required %h", got, out_valid, ref_dec(32'h00108133, 64'h4004));
        end
    endtask

    task automatic test_reset_mid_stall();
        clean();
        out_ready = 1'b0;
        in_instr = 32'h00500093; in_pc = 64'h5000; in_valid = 1'b1;
        step();
        in_instr = 32'h00108133; in_pc = 64'h5004;
        step();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (got !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_async got=%h v=%b rdy=%b required all 0", got, out_valid, in_ready);
        end
        step();
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_busy_clear v=%b rdy=%b required 0/1", out_valid, in_ready);
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || got !== ref_dec(32'h00108133, 64'h5004)) begin
            failures++;
            $display("FAIL rst_accept got=%h required %h", got, ref_dec(32'h00108133, 64'h5004));
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [7] = '{7'h13, 7'h33, 7'h1B, 7'h3B, 7'h37, 7'h03, 7'h23};
        logic [31:0] mbusy = '0;
        logic        mvalid = 1'b0;
        logic        exp_ready, xfer;
        exp_t        mexp = '0;
        exp_t        e;
        int          k;
        clean();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            k = $urandom_range(0, 7);
            in_instr = $urandom;
            if (k < 7) begin
                in_instr[6:0]   = ops[k];
                in_instr[11:7]  = 5'($urandom_range(0, 7));
                in_instr[19:15] = 5'($urandom_range(0, 7));
                in_instr[24:20] = 5'($urandom_range(0, 7));
            end
            in_pc     = {$urandom, $urandom};
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            wb_valid  = ($urandom_range(0, 2) == 0);
            wb_addr   = 5'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 39) == 0);
            e = ref_dec(in_instr, in_pc);
            exp_ready = !flush && !(mbusy[e.a] || mbusy[e.b]) && (!mvalid || out_ready);
            @(negedge clk);
            checks++;
            if (in_ready !== exp_ready || out_valid !== mvalid) begin
                failures++;
                $display("FAIL rnd_handshake cyc=%0d rdy=%b v=%b required rdy=%b v=%b", cyc, in_ready, out_valid, exp_ready, mvalid);
            end
            if (mvalid) begin
                checks++;
                if (got !== mexp) begin
                    failures++;
                    $display("FAIL rnd_bundle cyc=%0d got=%h required %h", cyc, got, mexp);
                end
            end
            if (flush) begin
                mvalid = 1'b0;
                mbusy  = '0;
            end else begin
                xfer = in_valid && exp_ready;
                if (wb_valid && wb_addr != 5'd0) mbusy[wb_addr] = 1'b0;
                if (xfer && e.rw) mbusy[e.c] = 1'b1;
                if (xfer) begin
                    mvalid = 1'b1;
                    mexp   = e;
                end else if (out_ready) begin
                    mvalid = 1'b0;
                end
            end
            step();
        end
        flush = 1'b0; in_valid = 1'b0; wb_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_raw_hazard();
        test_sub_lui();
        test_backpressure();
        test_illegal();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
